// File: rtl/seq_mult_n.sv
// Sequential shift-and-add multiplier with start/done handshake and optional
// two's-complement mode; one add/shift step per clock, WIDTH steps per product.
module seq_mult_n #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      STEPS   = CW'(WIDTH);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [2*WIDTH-1:0] PROD_ONE = (2*WIDTH)'(1);

  typedef enum logic {IDLE, RUN} state_t;

  // |v| in signed mode; the magnitude of -2^(W-1) wraps to 2^(W-1), which is
  // exactly the unsigned value we want.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                    sm);
    logic signed [WIDTH-1:0] neg_v;
    neg_v = -v;
    return (sm && v[WIDTH-1]) ? $unsigned(neg_v) : $unsigned(v);
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_negate(input logic [2*WIDTH-1:0] v,
                                                     input logic              n);
    return n ? (~v + PROD_ONE) : v;
  endfunction

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   p_reg;
  logic               neg;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] pa_next;

  assign sum     = {1'b0, p_reg} + {1'b0, (a_reg[0] ? b_reg : '0)};
  assign pa_next = {sum, a_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      count   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      p_reg   <= '0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= magnitude(a, signed_mode);
            b_reg <= magnitude(b, signed_mode);
            p_reg <= '0;
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            count <= STEPS;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // carry lands in P's MSB, P's LSB slides into A's MSB
          p_reg <= pa_next[2*WIDTH-1:WIDTH];
          a_reg <= pa_next[WIDTH-1:0];
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            product <= cond_negate(pa_next, neg);
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_n.sv
// Self-checking bench for seq_mult_n at WIDTH = 4, 8 and 16 against an
// integer-arithmetic reference model.
module tb_seq_mult_n;

  logic        clk;
  logic        rst;
  logic [2:0]  start;
  logic        sm;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;

  int vectors;
  int miscompares;

  seq_mult_n #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start[0]), .signed_mode(sm),
    .a(a[3:0]), .b(b[3:0]), .busy(busy[0]), .done(done[0]), .product(p4)
  );
  seq_mult_n #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start[1]), .signed_mode(sm),
    .a(a[7:0]), .b(b[7:0]), .busy(busy[1]), .done(done[1]), .product(p8)
  );
  seq_mult_n #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start[2]), .signed_mode(sm),
    .a(a), .b(b), .busy(busy[2]), .done(done[2]), .product(p16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wof(input int k);
    return (k == 0) ? 4 : (k == 1) ? 8 : 16;
  endfunction

  function automatic logic [31:0] getp(input int k);
    case (k)
      0:       return {24'd0, p4};
      1:       return {16'd0, p8};
      default: return p16;
    endcase
  endfunction

  // Reference: interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [31:0] ref_prod(input int w, input logic smode,
                                           input logic [15:0] x, input logic [15:0] y);
    longint xv, yv, r, m;
    m  = (longint'(1) << w) - 1;
    xv = longint'(x) & m;
    yv = longint'(y) & m;
    if (smode && x[w-1]) xv = xv - (longint'(1) << w);
    if (smode && y[w-1]) yv = yv - (longint'(1) << w);
    r = (xv * yv) & ((longint'(1) << (2 * w)) - 1);
    return r[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance k and wait (bounded) for its done pulse.
  task automatic do_mult(input int k, input logic smv, input logic [15:0] x,
                         input logic [15:0] y, output logic [31:0] res,
                         output int lat, output int bcnt);
    a = x; b = y; sm = smv;
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done[k] && lat < 100) begin
      if (busy[k]) bcnt++;
      tick();
      lat++;
    end
    res = getp(k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (busy[k] !== 1'b0 || done[k] !== 1'b0 || getp(k) !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_state w=%0d: busy=%b done=%b product=%h, want 0/0/0",
                 wof(k), busy[k], done[k], getp(k));
      end
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] res;
    int lat, bcnt;
    do_mult(1, 1'b0, 16'd13, 16'd11, res, lat, bcnt);
    vectors++;
    if (res !== 32'h008F) begin
      miscompares++; $display("FAIL u13x11: got %h want 008F", res);
    end
    vectors++;
    if (lat !== 8) begin
      miscompares++; $display("FAIL u13x11_latency: got %0d want 8", lat);
    end
    vectors++;
    if (bcnt !== 8) begin
      miscompares++; $display("FAIL u13x11_busy_cycles: got %0d want 8", bcnt);
    end
    do_mult(1, 1'b0, 16'd255, 16'd255, res, lat, bcnt);
    vectors++;
    if (res !== 32'hFE01) begin
      miscompares++; $display("FAIL u255x255: got %h want FE01", res);
    end
    do_mult(1, 1'b0, 16'd0, 16'd200, res, lat, bcnt);
    vectors++;
    if (res !== 32'h0000) begin
      miscompares++; $display("FAIL u0x200: got %h want 0000", res);
    end
    do_mult(1, 1'b0, 16'd1, 16'd255, res, lat, bcnt);
    vectors++;
    if (res !== 32'h00FF) begin
      miscompares++; $display("FAIL u1x255: got %h want 00FF", res);
    end
    do_mult(2, 1'b0, 16'hFFFF, 16'hFFFF, res, lat, bcnt);
    vectors++;
    if (res !== 32'hFFFE0001 || lat !== 16) begin
      miscompares++;
      $display("FAIL u16_ffffxffff: got %h lat %0d want FFFE0001 lat 16", res, lat);
    end
  endtask

  task automatic test_signed();
    logic [31:0] res;
    int lat, bcnt;
    logic [15:0] sa [5] = '{16'hFD, 16'h80, 16'h80, 16'hFF, 16'hFD};
    logic [15:0] sb [5] = '{16'h05, 16'h80, 16'h7F, 16'hFF, 16'h05};
    logic        ms [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ex [5] = '{32'hFFF1, 32'h4000, 32'hC080, 32'h0001, 32'h04F1};
    for (int i = 0; i < 5; i++) begin
      do_mult(1, ms[i], sa[i], sb[i], res, lat, bcnt);
      vectors++;
      if (res !== ex[i]) begin
        miscompares++;
        $display("FAIL signed8_%0d: %h x %h mode %b got %h want %h",
                 i, sa[i], sb[i], ms[i], res, ex[i]);
      end
    end
    do_mult(2, 1'b1, 16'h8000, 16'h0002, res, lat, bcnt);
    vectors++;
    if (res !== 32'hFFFF0000) begin
      miscompares++; $display("FAIL s16_8000x0002: got %h want FFFF0000", res);
    end
  endtask

  task automatic test_ignore_mid_run();
    int cyc;
    a = 16'd13; b = 16'd11; sm = 1'b0;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    cyc = 0;
    while (!done[1] && cyc < 100) begin
      if (cyc >= 2 && cyc <= 4) begin
        start[1] = 1'b1; a = 16'd99; b = 16'd77; sm = 1'b1;
      end else begin
        start[1] = 1'b0;
      end
      tick();
      cyc++;
    end
    start[1] = 1'b0;
    vectors++;
    if (p8 !== 16'h008F || cyc !== 8) begin
      miscompares++;
      $display("FAIL ignore_mid_run: got %h after %0d cycles want 008F after 8", p8, cyc);
    end
    tick();
    vectors++;
    if (busy[1] !== 1'b0 || done[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_mid_run_idle: busy=%b done=%b want 0/0", busy[1], done[1]);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    a = 16'd7; b = 16'd9; sm = 1'b0;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    cyc = 0;
    while (!done[1] && cyc < 100) begin tick(); cyc++; end
    vectors++;
    if (p8 !== 16'd63) begin
      miscompares++; $display("FAIL b2b_first: got %h want 003F", p8);
    end
    a = 16'd200; b = 16'd3;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    vectors++;
    if (done[1] !== 1'b0 || busy[1] !== 1'b1 || p8 !== 16'd63) begin
      miscompares++;
      $display("FAIL b2b_accept: done=%b busy=%b product=%h want 0/1/003F",
               done[1], busy[1], p8);
    end
    cyc = 0;
    while (!done[1] && cyc < 100) begin tick(); cyc++; end
    vectors++;
    if (cyc !== 8 || p8 !== 16'd600) begin
      miscompares++;
      $display("FAIL b2b_second: got %h after %0d cycles want 0258 after 8", p8, cyc);
    end
    tick();
    tick();
    vectors++;
    if (p8 !== 16'd600 || done[1] !== 1'b0) begin
      miscompares++; $display("FAIL b2b_hold: product=%h done=%b want 0258/0", p8, done[1]);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    a = 16'd255; b = 16'd255; sm = 1'b0;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy[1] !== 1'b0 || p8 !== 16'd0) begin
      miscompares++;
      $display("FAIL abort_state: busy=%b product=%h want 0/0000", busy[1], p8);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done[1]) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen) begin
      miscompares++; $display("FAIL abort_no_done: done seen=1 want 0");
    end
  endtask

  task automatic test_rst_start();
    bit seen;
    a = 16'd5; b = 16'd5; sm = 1'b0;
    rst = 1'b1;
    start[1] = 1'b1;
    tick();
    rst = 1'b0;
    start[1] = 1'b0;
    vectors++;
    if (busy[1] !== 1'b0) begin
      miscompares++; $display("FAIL rst_start_busy: got %b want 0", busy[1]);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done[1] || busy[1]) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen || p8 !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_start_idle: activity=%b product=%h want 0/0000", seen, p8);
    end
  endtask

  task automatic test_random();
    logic [31:0] res, exp_v;
    logic [15:0] x, y;
    int lat, bcnt;
    for (int k = 0; k < 3; k++) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 1000; i++) begin
          x = 16'($urandom);
          y = 16'($urandom);
          exp_v = ref_prod(wof(k), m[0], x, y);
          do_mult(k, m[0], x, y, res, lat, bcnt);
          vectors++;
          if (res !== exp_v || lat !== wof(k)) begin
            miscompares++;
            $display("FAIL random w=%0d mode=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                     wof(k), m, x, y, res, lat, exp_v, wof(k));
          end
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start = 3'b000;
    sm = 1'b0;
    a = '0;
    b = '0;
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_ignore_mid_run();
    test_back_to_back();
    test_reset_abort();
    test_rst_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
